div_issue_ctrl: RTL

DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

---
 rtl/div_issue_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/div_issue_ctrl.sv
// Issue controller: a 2-entry operand FIFO feeding a fixed-latency divider, with result capture and hold.
// Optional macro DIV_ZERO_BYPASS_EN completes zero-divisor operations without issuing them.
module div_issue_ctrl #(
   parameter int WIDTH   = 16,
   parameter int DIV_LAT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_dividend,
   input  logic [WIDTH-1:0] in_divisor,
   output logic [WIDTH-1:0] div_dividend,
   output logic [WIDTH-1:0] div_divisor,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             out_dz,
   output logic             busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [3:0]       lat_q, lat_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [WIDTH-1:0] fifo_dvd_q [2];
   logic [WIDTH-1:0] fifo_dsr_q [2];
   logic [WIDTH-1:0] div_dvd_q, div_dvd_d;
   logic [WIDTH-1:0] div_dsr_q, div_dsr_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dz_q, dz_d;
   logic             push, pop, zero_head;
   logic [WIDTH-1:0] head_dvd, head_dsr;

   // in_ready is forced low while reset is held, not just after the FIFO clears.
   assign in_ready = ~rst & (cnt_q != 2'd2);
   assign push     = in_valid & in_ready;
   assign head_dvd = fifo_dvd_q[rd_ptr_q];
   assign head_dsr = fifo_dsr_q[rd_ptr_q];

`ifdef DIV_ZERO_BYPASS_EN
   assign zero_head = (head_dsr == '0);
`else
   assign zero_head = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      div_dvd_d = div_dvd_q;
      div_dsr_d = div_dsr_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dz_d      = dz_q;
      pop       = 1'b0;
      case (state_q)
         IDLE: pop = (cnt_q != 2'd0);
         ISSUE: begin
            lat_d = lat_q - 4'd1;
            if (lat_q == 4'd1) begin
               quo_d   = div_quotient;
               rem_d   = div_remainder;
               dz_d    = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               if (cnt_q != 2'd0) pop = 1'b1;
               else               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A pop from IDLE or a DONE handshake either bypasses a zero divisor or issues the pair.
      if (pop) begin
         if (zero_head) begin
            quo_d   = '1;
            rem_d   = head_dvd;
            dz_d    = 1'b1;
            state_d = DONE;
         end else begin
            div_dvd_d = head_dvd;
            div_dsr_d = head_dsr;
            lat_d     = 4'(DIV_LAT);
            state_d   = ISSUE;
         end
      end
   end

   assign cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
   assign rd_ptr_d = rd_ptr_q ^ pop;
   assign wr_ptr_d = wr_ptr_q ^ push;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         lat_q     <= '0;
         cnt_q     <= '0;
         rd_ptr_q  <= 1'b0;
         wr_ptr_q  <= 1'b0;
         div_dvd_q <= '0;
         div_dsr_q <= '0;
         quo_q     <= '0;
         rem_q     <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         cnt_q     <= cnt_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         div_dvd_q <= div_dvd_d;
         div_dsr_q <= div_dsr_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dz_q      <= dz_d;
      end
   end

   // FIFO storage needs no reset: occupancy is governed by cnt_q and the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_dvd_q[wr_ptr_q] <= in_dividend;
         fifo_dsr_q[wr_ptr_q] <= in_divisor;
      end
   end

   assign div_dividend  = div_dvd_q;
   assign div_divisor   = div_dsr_q;
   assign out_quotient  = quo_q;
   assign out_remainder = rem_q;
   assign out_dz        = dz_q;
   assign out_valid     = (state_q == DONE);
   assign busy          = (state_q != IDLE) || (cnt_q != 2'd0);

endmodule
